// File: rtl/rc5_words_to_bytes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rc5_words_to_bytes                                           |
// | Description : Serializes a block of C RC5 words of W bits into a           |
// |               little-endian byte stream over a valid/ready handshake.      |
// |               Byte i comes from bits [8*i+7:8*i] of the captured block.    |
// |               Optional feature macro RC5_W2B_CHECKSUM_EN appends one       |
// |               trailing byte holding the XOR of all data bytes.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rc5_words_to_bytes #(
    parameter int W = 32,
    parameter int U = 4,
    parameter int C = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [C*W-1:0] words_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     byte_out,
    output logic           last
);

    localparam int N  = C * U;
    localparam int IW = $clog2(N + 1);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
`ifdef RC5_W2B_CHECKSUM_EN
    // Index N addresses the trailing checksum byte.
    localparam logic [IW-1:0] FINAL_IDX = IW'(N);
`else
    localparam logic [IW-1:0] FINAL_IDX = IW'(N - 1);
`endif

    // Word width must split exactly into U bytes.
    generate
        if ((W % 8 != 0) || (U != W / 8)) begin : g_bad_params
            $error("rc5_words_to_bytes: W must be a multiple of 8 and U must equal W/8");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [C*W-1:0] block;
    logic [IW-1:0]  idx;
    logic [7:0]     data_byte;
    logic           in_hs;
    logic           out_hs;
    logic           at_final;
    logic [7:0]     block_bytes [N];

    // Byte view of the captured block: little-endian across and within words.
    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_bytes
            assign block_bytes[k] = block[8*k +: 8];
        end
    endgenerate

    assign data_byte = block_bytes[idx[SW-1:0]];
    assign at_final  = (idx == FINAL_IDX);
    assign in_hs     = (state == IDLE) && in_valid;
    assign out_hs    = (state == SEND) && out_ready;
    assign last      = (state == SEND) && at_final;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs, decoded from the registered state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready && at_final) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Block capture and byte index; the index stops at the final byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            block <= '0;
            idx   <= '0;
        end else if (in_hs) begin
            block <= words_in;
            idx   <= '0;
        end else if (out_hs && !at_final) begin
            idx   <= idx + 1'b1;
        end
    end

`ifdef RC5_W2B_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of the data bytes as each one is accepted by the sink.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= 8'h00;
        end else if (in_hs) begin
            csum <= 8'h00;
        end else if (out_hs && !at_final) begin
            csum <= csum ^ data_byte;
        end
    end

    assign byte_out = at_final ? csum : data_byte;
`else
    assign byte_out = data_byte;
`endif

endmodule
`default_nettype wire
